// File: rtl/iarray_pkg.sv
// Shared definitions for the wrapped dual-port array family: read-engine FSM states,
// a constant clog2 helper and the default array read latency.
package iarray_pkg;

   localparam int IARRAY_RDLAT = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rdeng_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((2 ** result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/iarray_rdeng_fifo.sv
// First-word-fall-through skid FIFO for the read engine; the head entry is visible on
// rd_data whenever vld is high, and count reports the current occupancy.
module iarray_rdeng_fifo #(
   parameter int DW = 33,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          vld,
   output logic [AW:0]   count
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          pop_s;

   assign vld     = (count_q != {(AW + 1){1'b0}});
   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign pop_s   = rd_en & vld;

   // next-state for storage, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en, pop_s})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DW{1'b0}};
         end
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW + 1){1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/iarray_rdeng.sv
// Streaming burst read engine for the wrapped dual-port arrays.
// Optional parity check on returned words: define IARRAY_RDENG_PARITY_EN.
module iarray_rdeng
   import iarray_pkg::*;
#(
   parameter int ADDRBIT = 9,
   parameter int WIDTH   = 32,
   parameter int RDLAT   = IARRAY_RDLAT,
   parameter int SKIDBIT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_vld,
   output logic               cmd_rdy,
   input  logic [ADDRBIT-1:0] cmd_addr,
   input  logic [ADDRBIT-1:0] cmd_len,
   output logic [ADDRBIT-1:0] ara,
   output logic               are,
   input  logic [WIDTH-1:0]   ado,
   output logic               dat_vld,
   input  logic               dat_rdy,
   output logic [WIDTH-1:0]   dat,
   output logic               dat_last,
   output logic               busy,
   output logic               perr
);

   localparam int DEPTH = 2 ** SKIDBIT;
   localparam int CW    = clog2(DEPTH + RDLAT + 2) + 1;

   rdeng_state_e       state_q, state_d;
   logic [ADDRBIT-1:0] rd_addr_q, rd_addr_d;
   logic [ADDRBIT-1:0] remaining_q, remaining_d;
   logic [ADDRBIT-1:0] ara_q, ara_d;
   logic               are_q, are_d;
   logic               are_last_q, are_last_d;
   logic               busy_q, busy_d;
   logic [RDLAT-1:0]   pipe_vld_q, pipe_vld_d;
   logic [RDLAT-1:0]   pipe_last_q, pipe_last_d;

   logic [SKIDBIT:0]   fifo_count_s;
   logic               fifo_vld_s;
   logic [WIDTH:0]     fifo_head_s;
   logic               pop_s;
   logic               issue_s;
   logic               credit_ok_s;
   logic [CW-1:0]      inflight_s;
   logic [CW-1:0]      occ_s;
   logic [ADDRBIT-1:0] cur_addr_s;
   logic [ADDRBIT-1:0] cur_rem_s;

   assign pop_s    = fifo_vld_s & dat_rdy;
   assign cmd_rdy  = (state_q == IDLE) & ~rst;
   assign ara      = ara_q;
   assign are      = are_q;
   assign busy     = busy_q;
   assign dat_vld  = fifo_vld_s;
   assign dat      = fifo_vld_s ? fifo_head_s[WIDTH-1:0] : {WIDTH{1'b0}};
   assign dat_last = fifo_vld_s & fifo_head_s[WIDTH];

   // slot accounting: reads in the are stage and the latency pipe each own a FIFO slot
   // reserved up front; a pop this cycle frees one, so issue may use it immediately
   always_comb begin
      inflight_s = CW'(are_q);
      for (int i = 0; i < RDLAT; i++) begin
         inflight_s = inflight_s + CW'(pipe_vld_q[i]);
      end
      occ_s       = CW'(fifo_count_s) + inflight_s - CW'(pop_s);
      credit_ok_s = (occ_s < CW'(DEPTH));
   end

   // latency pipe advance
   always_comb begin
      pipe_vld_d     = pipe_vld_q;
      pipe_last_d    = pipe_last_q;
      pipe_vld_d[0]  = are_q;
      pipe_last_d[0] = are_last_q;
      for (int i = 1; i < RDLAT; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_last_d[i] = pipe_last_q[i-1];
      end
   end

   // FSM next state and read issue; the accepting cycle already issues the first read
   // so the registered are appears in the cycle straight after the command
   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      remaining_d = remaining_q;
      ara_d       = ara_q;
      are_d       = 1'b0;
      are_last_d  = 1'b0;
      busy_d      = busy_q;
      issue_s     = 1'b0;
      cur_addr_s  = rd_addr_q;
      cur_rem_s   = remaining_q;
      case (state_q)
         IDLE: begin
            if (cmd_vld) begin
               issue_s    = 1'b1;
               cur_addr_s = cmd_addr;
               cur_rem_s  = cmd_len;
               busy_d     = 1'b1;
            end else begin
               issue_s = 1'b0;
            end
         end
         ISSUE: begin
            issue_s = credit_ok_s;
         end
         DRAIN: begin
            if (pop_s && fifo_head_s[WIDTH]) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (issue_s) begin
         ara_d       = cur_addr_s;
         are_d       = 1'b1;
         are_last_d  = (cur_rem_s == {ADDRBIT{1'b0}});
         rd_addr_d   = cur_addr_s + ADDRBIT'(1);
         remaining_d = cur_rem_s - ADDRBIT'(1);
         state_d     = (cur_rem_s == {ADDRBIT{1'b0}}) ? DRAIN : ISSUE;
      end else begin
         are_d = 1'b0;
      end
   end

   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_addr_q   <= {ADDRBIT{1'b0}};
         remaining_q <= {ADDRBIT{1'b0}};
         ara_q       <= {ADDRBIT{1'b0}};
         are_q       <= 1'b0;
         are_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         pipe_vld_q  <= {RDLAT{1'b0}};
         pipe_last_q <= {RDLAT{1'b0}};
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         remaining_q <= remaining_d;
         ara_q       <= ara_d;
         are_q       <= are_d;
         are_last_q  <= are_last_d;
         busy_q      <= busy_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_last_q <= pipe_last_d;
      end
   end

   iarray_rdeng_fifo #(
      .DW (WIDTH + 1),
      .AW (SKIDBIT)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (pipe_vld_q[RDLAT-1]),
      .wr_data ({pipe_last_q[RDLAT-1], ado}),
      .rd_en   (pop_s),
      .rd_data (fifo_head_s),
      .vld     (fifo_vld_s),
      .count   (fifo_count_s)
   );

`ifdef IARRAY_RDENG_PARITY_EN
   function automatic logic parity_bad(input logic [WIDTH-1:0] word);
      return ^word;
   endfunction

   logic perr_q, perr_d;

   assign perr = perr_q;

   // sticky flag: any word entering the FIFO with odd overall parity
   always_comb begin
      if (pipe_vld_q[RDLAT-1] && parity_bad(ado)) begin
         perr_d = 1'b1;
      end else begin
         perr_d = perr_q;
      end
   end

   // parity flag register
   always_ff @(posedge clk) begin
      if (rst) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end
`else
   assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_iarray_rdeng.sv
// Self-checking bench for iarray_rdeng: a behavioural array with 3-cycle read latency
// and a scoreboard that derives every expected word from burst address arithmetic.
module tb_iarray_rdeng;
   import iarray_pkg::*;

   localparam int AB  = 9;
   localparam int W   = 32;
   localparam int LAT = IARRAY_RDLAT;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_vld;
   logic          cmd_rdy;
   logic [AB-1:0] cmd_addr;
   logic [AB-1:0] cmd_len;
   logic [AB-1:0] ara;
   logic          are;
   logic [W-1:0]  ado;
   logic          dat_vld;
   logic          dat_rdy;
   logic [W-1:0]  dat;
   logic          dat_last;
   logic          busy;
   logic          perr;

   int tests = 0;
   int fails = 0;

   logic [W-1:0]  ram [512];
   logic [AB-1:0] arr_addr_q;
   logic [W-1:0]  arr_data_q;

   int            cyc = 0;
   int            acc_cyc;
   int            first_are_cyc;
   int            first_vld_cyc;
   int            stall_are;
   int            vld_cycles;
   logic [AB-1:0] iss_q [$];
   logic [W-1:0]  got_d [$];
   logic          got_l [$];

   iarray_rdeng #(
      .ADDRBIT (AB),
      .WIDTH   (W),
      .RDLAT   (LAT),
      .SKIDBIT (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_vld  (cmd_vld),
      .cmd_rdy  (cmd_rdy),
      .cmd_addr (cmd_addr),
      .cmd_len  (cmd_len),
      .ara      (ara),
      .are      (are),
      .ado      (ado),
      .dat_vld  (dat_vld),
      .dat_rdy  (dat_rdy),
      .dat      (dat),
      .dat_last (dat_last),
      .busy     (busy),
      .perr     (perr)
   );

   always #5 clk = ~clk;

   // array model: registered address, RAM read, registered data out (3 cycles)
   always @(posedge clk) begin
      arr_addr_q <= ara;
      arr_data_q <= ram[arr_addr_q];
      ado        <= arr_data_q;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      if (!rst) begin
         if (cmd_vld && cmd_rdy) acc_cyc = cyc;
         if (are) begin
            iss_q.push_back(ara);
            if (first_are_cyc < 0) first_are_cyc = cyc;
            if (!dat_rdy) stall_are++;
         end
         if (dat_vld) begin
            vld_cycles++;
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            if (dat_rdy) begin
               got_d.push_back(dat);
               got_l.push_back(dat_last);
            end
         end
      end
   endtask

   // sample mid-cycle, then advance to just after the next rising edge
   task automatic tick();
      @(negedge clk);
      sample();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      acc_cyc       = -1;
      first_are_cyc = -1;
      first_vld_cyc = -1;
      stall_are     = 0;
      vld_cycles    = 0;
      iss_q.delete();
      got_d.delete();
      got_l.delete();
   endtask

   // mode 0: always ready, 1: random ready, 2: 10-cycle stall at first dat_vld
   task automatic run_burst(input logic [AB-1:0] addr, input logic [AB-1:0] len,
                            input int mode, input string tag);
      int n;
      int guard;
      int stall_left;
      bit started;
      clear();
      n          = int'(len) + 1;
      guard      = 0;
      stall_left = 0;
      started    = 1'b0;
      cmd_addr   = addr;
      cmd_len    = len;
      cmd_vld    = 1'b1;
      while (got_d.size() < n && guard < 6000) begin
         case (mode)
            1: dat_rdy = 1'($urandom_range(0, 1));
            2: begin
               if (!started && dat_vld) begin
                  started    = 1'b1;
                  stall_left = 10;
               end
               if (stall_left > 0) begin
                  dat_rdy = 1'b0;
                  stall_left--;
               end else begin
                  dat_rdy = 1'b1;
               end
            end
            default: dat_rdy = 1'b1;
         endcase
         tick();
         if (acc_cyc >= 0) cmd_vld = 1'b0;
         guard++;
      end
      cmd_vld = 1'b0;
      dat_rdy = 1'b1;
      check({tag, "_timeout"}, guard < 6000, 1);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_cmd_rdy_after"}, cmd_rdy, 1);
      check({tag, "_first_are_cyc"}, first_are_cyc, acc_cyc + 1);
      check({tag, "_first_vld_cyc"}, first_vld_cyc, acc_cyc + 2 + LAT);
      check({tag, "_are_count"}, iss_q.size(), n);
      check({tag, "_word_count"}, got_d.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < iss_q.size())
            check($sformatf("%s_ara[%0d]", tag, i), iss_q[i], (int'(addr) + i) % 512);
         if (i < got_d.size()) begin
            check($sformatf("%s_dat[%0d]", tag, i), got_d[i], ram[(int'(addr) + i) % 512]);
            check($sformatf("%s_last[%0d]", tag, i), got_l[i], (i == n - 1));
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_are"}, are, 0);
      check({tag, "_ara"}, ara, 0);
      check({tag, "_dat_vld"}, dat_vld, 0);
      check({tag, "_dat_last"}, dat_last, 0);
      check({tag, "_dat"}, dat, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_perr"}, perr, 0);
   endtask

   initial begin
      logic [W-1:0] w;
      int guard;
      for (int i = 0; i < 512; i++) begin
         w      = $urandom;
         w[W-1] = ^w[W-2:0];
         ram[i] = w;
      end
      rst      = 1'b1;
      cmd_vld  = 1'b0;
      cmd_addr = 9'h000;
      cmd_len  = 9'h000;
      dat_rdy  = 1'b1;
      clear();

      // reset behaviour
      tick();
      tick();
      check("rst_cmd_rdy", cmd_rdy, 0);
      check_idle_outputs("rst");
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_cmd_rdy", cmd_rdy, 1);
      @(posedge clk);
      #1;

      run_burst(9'h005, 9'h000, 0, "single");
      run_burst(9'h1FE, 9'h003, 0, "wrap");
      run_burst(9'h040, 9'h00F, 2, "stall");
      check("stall_are_le4", stall_are <= 4, 1);
      run_burst(9'h000, 9'h1FF, 1, "rand512");

      // reset two cycles after the first read of a burst
      clear();
      cmd_addr = 9'h100;
      cmd_len  = 9'h00F;
      cmd_vld  = 1'b1;
      guard    = 0;
      while (first_are_cyc < 0 && guard < 20) begin
         tick();
         if (acc_cyc >= 0) cmd_vld = 1'b0;
         guard++;
      end
      cmd_vld = 1'b0;
      check("midrst_started", first_are_cyc >= 0, 1);
      tick();
      rst = 1'b1;
      tick();
      check("midrst_cmd_rdy", cmd_rdy, 0);
      check_idle_outputs("midrst");
      rst = 1'b0;
      clear();
      for (int i = 0; i < 12; i++) tick();
      check("midrst_no_dat_vld", vld_cycles, 0);
      check("midrst_no_are", iss_q.size(), 0);
      run_burst(9'h0AB, 9'h000, 0, "post_midrst");

      // parity: corrupt word 3, burst over 0..7
      check("perr_before", perr, 0);
      w      = ram[3];
      w[0]   = ~w[0];
      ram[3] = w;
      run_burst(9'h000, 9'h007, 0, "parity");
`ifdef IARRAY_RDENG_PARITY_EN
      check("perr_set", perr, 1);
      tick();
      check("perr_sticky", perr, 1);
`else
      check("perr_tied_low", perr, 0);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("perr_cleared", perr, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
